// File: rtl/sram_controller.sv
// Read-only frame sweeper for the external 1Mx16 async SRAM: re-reads the frame window until best_angle_rdy.
// Optional pass limit is compiled in with `define SRAM_CTRL_PASS_LIMIT_EN.
//   state | meaning
//   IDLE  | strobes inactive, waiting for start
//   READ  | strobes active, sweeping the frame window with wrap
//   DONE  | strobes inactive, waiting for start to drop
module sram_controller #(
   parameter logic [19:0] BASE_ADDR     = 20'h00000,
   parameter int unsigned FRAME_WORDS   = 4096,
   parameter int unsigned ACCESS_CYCLES = 1,
   parameter int unsigned MAX_PASSES    = 36
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        best_angle_rdy,
   output logic [19:0] addr,
   output logic        CE_n,
   output logic        OE_n,
   output logic        WE_n,
   output logic        UB_n,
   output logic        LB_n
);

   localparam int unsigned DW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LOAD = DW'(ACCESS_CYCLES - 1);
   localparam logic [19:0] LAST_ADDR = 20'(32'(BASE_ADDR) + FRAME_WORDS - 32'd1);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [19:0]     addr_q;
   logic [DW-1:0]   dwell;
   logic            word_done;
   logic            frame_wrap;

   assign word_done  = (dwell == '0);
   assign frame_wrap = (state == READ) && word_done && (addr_q == LAST_ADDR);

`ifdef SRAM_CTRL_PASS_LIMIT_EN
   logic [31:0] pass_cnt;
   logic        pass_limit_hit;

   assign pass_limit_hit = frame_wrap && (pass_cnt == 32'(MAX_PASSES - 1));

   always_ff @(posedge clk) begin
      if (rst || state_nxt != READ)
         pass_cnt <= '0;
      else if (frame_wrap)
         pass_cnt <= pass_cnt + 32'd1;
   end
`else
   logic pass_limit_hit;
   assign pass_limit_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start == 1'b1) state_nxt = READ;
         // stop beats a simultaneous wrap, so it is evaluated first
         READ: if (best_angle_rdy === 1'b1 || pass_limit_hit) state_nxt = DONE;
         DONE: if (start == 1'b0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // addr_q is parked at BASE_ADDR outside READ so the sweep always starts from word 0
   always_ff @(posedge clk) begin
      if (rst || state_nxt != READ) begin
         addr_q <= BASE_ADDR;
         dwell  <= DWELL_LOAD;
      end else if (state == READ) begin
         if (word_done) begin
            dwell  <= DWELL_LOAD;
            addr_q <= (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 20'd1;
         end else begin
            dwell <= dwell - 1'b1;
         end
      end else begin
         addr_q <= BASE_ADDR;
         dwell  <= DWELL_LOAD;
      end
   end

   always_comb begin
      CE_n = 1'b1;
      OE_n = 1'b1;
      UB_n = 1'b1;
      LB_n = 1'b1;
      WE_n = 1'b1;
      if (state == READ) begin
         CE_n = 1'b0;
         OE_n = 1'b0;
         UB_n = 1'b0;
         LB_n = 1'b0;
      end
   end

   assign addr = addr_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: four instances with different geometry share clk/rst/start.
// Pass-limit expectations follow SRAM_CTRL_PASS_LIMIT_EN when defined.
module tb_sram_controller;

   logic clk, rst, start;
   logic best_a, best_b, best_c, best_d;
   logic [19:0] addr_a, addr_b, addr_c, addr_d;
   logic a_ce, a_oe, a_we, a_ub, a_lb;
   logic b_ce, b_oe, b_we, b_ub, b_lb;
   logic c_ce, c_oe, c_we, c_ub, c_lb;
   logic d_ce, d_oe, d_we, d_ub, d_lb;
   logic [4:0] sa, sb, sc, sd;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [4:0] S_ACT = 5'b00100;
   localparam logic [4:0] S_OFF = 5'b11111;

   assign sa = {a_ce, a_oe, a_we, a_ub, a_lb};
   assign sb = {b_ce, b_oe, b_we, b_ub, b_lb};
   assign sc = {c_ce, c_oe, c_we, c_ub, c_lb};
   assign sd = {d_ce, d_oe, d_we, d_ub, d_lb};

   sram_controller #(.BASE_ADDR(20'h00000), .FRAME_WORDS(8), .ACCESS_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .start(start), .best_angle_rdy(best_a), .addr(addr_a),
      .CE_n(a_ce), .OE_n(a_oe), .WE_n(a_we), .UB_n(a_ub), .LB_n(a_lb));

   sram_controller #(.BASE_ADDR(20'h00000), .FRAME_WORDS(4), .ACCESS_CYCLES(3)) u_b (
      .clk(clk), .rst(rst), .start(start), .best_angle_rdy(best_b), .addr(addr_b),
      .CE_n(b_ce), .OE_n(b_oe), .WE_n(b_we), .UB_n(b_ub), .LB_n(b_lb));

   sram_controller #(.BASE_ADDR(20'h00000), .FRAME_WORDS(4), .ACCESS_CYCLES(1), .MAX_PASSES(2)) u_c (
      .clk(clk), .rst(rst), .start(start), .best_angle_rdy(best_c), .addr(addr_c),
      .CE_n(c_ce), .OE_n(c_oe), .WE_n(c_we), .UB_n(c_ub), .LB_n(c_lb));

   sram_controller #(.BASE_ADDR(20'h00100), .FRAME_WORDS(3), .ACCESS_CYCLES(2)) u_d (
      .clk(clk), .rst(rst), .start(start), .best_angle_rdy(best_d), .addr(addr_d),
      .CE_n(d_ce), .OE_n(d_oe), .WE_n(d_we), .UB_n(d_ub), .LB_n(d_lb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      best_a = 1'b0; best_b = 1'b0; best_c = 1'b0; best_d = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (addr_a !== 20'h0 || sa !== S_OFF)
            $display("FAIL reset_idle[%0d]: addr=%h strobes=%b, expected addr=00000 strobes=%b", i, addr_a, sa, S_OFF);
         else n_pass++;
         n_checks++;
         if (addr_d !== 20'h00100 || sd !== S_OFF)
            $display("FAIL reset_idle_base[%0d]: addr=%h strobes=%b, expected addr=00100 strobes=%b", i, addr_d, sd, S_OFF);
         else n_pass++;
         @(negedge clk);
      end
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (addr_a !== 20'h0 || sa !== S_OFF)
         $display("FAIL reset_priority: addr=%h strobes=%b, expected addr=00000 strobes=%b", addr_a, sa, S_OFF);
      else n_pass++;
      rst = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_basic_sweep();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'(i % 8) || sa !== S_ACT)
            $display("FAIL basic_sweep[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_a, sa, 20'(i % 8), S_ACT);
         else n_pass++;
      end
      start = 1'b0;
   endtask

   task automatic test_dwell();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_b !== 20'((i / 3) % 4) || sb !== S_ACT)
            $display("FAIL dwell[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_b, sb, 20'((i / 3) % 4), S_ACT);
         else n_pass++;
         n_checks++;
         if (addr_d !== 20'h00100 + 20'((i / 2) % 3) || sd !== S_ACT)
            $display("FAIL dwell_base[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_d, sd, 20'h00100 + 20'((i / 2) % 3), S_ACT);
         else n_pass++;
      end
      start = 1'b0;
   endtask

   task automatic test_stop();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'(i % 8) || sa !== S_ACT)
            $display("FAIL stop_pre[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_a, sa, 20'(i % 8), S_ACT);
         else n_pass++;
         if (i == 11) best_b = 1'b1;
         if (i == 12) begin
            n_checks++;
            if (addr_b !== 20'h0 || sb !== S_OFF)
               $display("FAIL stop_at_wrap: addr=%h strobes=%b, expected addr=00000 strobes=%b", addr_b, sb, S_OFF);
            else n_pass++;
            best_b = 1'b0;
         end
      end
      best_a = 1'b1;
      @(negedge clk);
      n_checks++;
      if (addr_a !== 20'h0 || sa !== S_OFF)
         $display("FAIL stop: addr=%h strobes=%b, expected addr=00000 strobes=%b", addr_a, sa, S_OFF);
      else n_pass++;
      best_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'h0 || sa !== S_OFF)
            $display("FAIL done_hold[%0d]: addr=%h strobes=%b, expected addr=00000 strobes=%b", i, addr_a, sa, S_OFF);
         else n_pass++;
      end
      n_checks++;
      if (addr_b !== 20'h0 || sb !== S_OFF)
         $display("FAIL done_hold_wrap: addr=%h strobes=%b, expected addr=00000 strobes=%b", addr_b, sb, S_OFF);
      else n_pass++;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sa !== S_OFF)
         $display("FAIL done_release: strobes=%b, expected %b", sa, S_OFF);
      else n_pass++;
      start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'(i) || sa !== S_ACT)
            $display("FAIL restart[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_a, sa, 20'(i), S_ACT);
         else n_pass++;
      end
      start = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'(i) || sa !== S_ACT)
            $display("FAIL mid_reset_pre[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_a, sa, 20'(i), S_ACT);
         else n_pass++;
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (addr_a !== 20'h0 || sa !== S_OFF)
         $display("FAIL mid_reset: addr=%h strobes=%b, expected addr=00000 strobes=%b", addr_a, sa, S_OFF);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (addr_a !== 20'(i) || sa !== S_ACT)
            $display("FAIL mid_reset_restart[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_a, sa, 20'(i), S_ACT);
         else n_pass++;
      end
      start = 1'b0;
   endtask

   task automatic test_pass_limit();
      logic [4:0]  exp_s;
      logic [19:0] exp_a;
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
`ifdef SRAM_CTRL_PASS_LIMIT_EN
         exp_s = (i < 8) ? S_ACT : S_OFF;
         exp_a = (i < 8) ? 20'(i % 4) : 20'h0;
`else
         exp_s = S_ACT;
         exp_a = 20'(i % 4);
`endif
         n_checks++;
         if (addr_c !== exp_a || sc !== exp_s)
            $display("FAIL pass_limit[%0d]: addr=%h strobes=%b, expected addr=%h strobes=%b", i, addr_c, sc, exp_a, exp_s);
         else n_pass++;
         n_checks++;
         if ((a_we & b_we & c_we & d_we) !== 1'b1)
            $display("FAIL we_high[%0d]: we=%b%b%b%b, expected 1111", i, a_we, b_we, c_we, d_we);
         else n_pass++;
      end
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      best_a = 1'b0; best_b = 1'b0; best_c = 1'b0; best_d = 1'b0;
      test_reset();
      test_basic_sweep();
      test_dwell();
      test_stop();
      test_mid_reset();
      test_pass_limit();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
